// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared types and defaults for the Strassen matmul loader and core
package matmul_pkg;

  localparam int BIT_PREC_DEFAULT = 8;
  localparam int N_DEFAULT        = 2;
  localparam int FRAME            = 2 * N_DEFAULT * N_DEFAULT;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIRE,
    WAIT
  } loader_state_t;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_STAGE1,
    CORE_STAGE2,
    CORE_DONE
  } core_state_t;

  // Elements per frame: the A matrix followed by the B matrix.
  function automatic int frame_len(input int n);
    return 2 * n * n;
  endfunction

endpackage

// File: rtl/matmul_operand_loader.sv
// rtl/matmul_operand_loader.sv - assembles A/B operand matrices from a stream and fires the core
module matmul_operand_loader
  import matmul_pkg::*;
#(
  parameter int BIT_PREC = BIT_PREC_DEFAULT,
  parameter int N        = N_DEFAULT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic signed [BIT_PREC-1:0]                s_data,
  input  logic                                      s_last,
  output logic signed [N-1:0][N-1:0][BIT_PREC-1:0]  A,
  output logic signed [N-1:0][N-1:0][BIT_PREC-1:0]  B,
  output logic                                      start,
  input  logic                                      mm_valid,
  output logic                                      busy,
  output logic                                      frame_err
);

  localparam int NN        = N * N;
  localparam int FRAME_LEN = frame_len(N);
  localparam int CW        = $clog2(FRAME_LEN);

  loader_state_t  state;
  logic [CW-1:0]  count;
  logic           xfer;
  logic           last_slot;

  // Only LOAD accepts data; FIRE/WAIT back-pressure the stream so A/B stay put for the core.
  assign s_ready   = (state == LOAD);
  assign xfer      = s_valid && s_ready;
  assign last_slot = (count == CW'(FRAME_LEN - 1));

  // Loader FSM: element capture, frame checking, start pulse and busy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      A         <= '0;
      B         <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= LOAD;
        end
        LOAD: begin
          if (xfer) begin
            // Row-major placement: first N*N elements fill A, the next N*N fill B.
            for (int r = 0; r < N; r++) begin
              for (int c = 0; c < N; c++) begin
                if (count == CW'(r * N + c)) A[r][c] <= s_data;
                if (count == CW'(NN + r * N + c)) B[r][c] <= s_data;
              end
            end
            if (s_last && last_slot) begin
              count <= '0;
              state <= FIRE;
              start <= 1'b1;
              busy  <= 1'b1;
            end else if (s_last || last_slot) begin
              // s_last early or missing: drop the frame and resynchronise on the next element.
              count     <= '0;
              frame_err <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        FIRE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (mm_valid) begin
            busy  <= 1'b0;
            state <= LOAD;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_operand_loader.sv
// tb/tb_matmul_operand_loader.sv - scoreboard bench for the matmul operand loader
module tb_matmul_operand_loader;
  import matmul_pkg::*;

  localparam int BP  = BIT_PREC_DEFAULT;
  localparam int NM  = N_DEFAULT;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic s_valid;
  logic s_ready;
  logic signed [BP-1:0] s_data;
  logic s_last;
  logic signed [NM-1:0][NM-1:0][BP-1:0] A_o;
  logic signed [NM-1:0][NM-1:0][BP-1:0] B_o;
  logic start;
  logic mm_valid;
  logic busy;
  logic frame_err;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int done_cnt = 0;

  typedef struct {
    int a[4];
    int b[4];
    int c[4];
  } exp_t;

  exp_t sb[$];

  matmul_operand_loader #(.BIT_PREC(BP), .N(NM)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .A(A_o), .B(B_o), .start(start), .mm_valid(mm_valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void matmul2(input int a[4], input int b[4], output int c[4]);
    for (int r = 0; r < 2; r++)
      for (int q = 0; q < 2; q++)
        c[r*2+q] = a[r*2] * b[q] + a[r*2+1] * b[2+q];
  endfunction

  task automatic push_exp(input int v[8], input int c[4]);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.a[i] = v[i];
      e.b[i] = v[4+i];
      e.c[i] = c[i];
    end
    sb.push_back(e);
  endtask

  task automatic push_model(input int v[8]);
    int a[4];
    int b[4];
    int c[4];
    for (int i = 0; i < 4; i++) begin
      a[i] = v[i];
      b[i] = v[4+i];
    end
    matmul2(a, b, c);
    push_exp(v, c);
  endtask

  // Called at a negedge; returns at the negedge after the last transfer.
  task automatic send_frame(input int v[8], input int n, input int last_pos, input bit keep);
    int t;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = v[i][BP-1:0];
      s_last  = (i == last_pos);
      t = 0;
      while (!s_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("ready_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
    end
    if (!keep) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    while (mm_valid !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk({tag, "_mm_timeout"}, 0, 1);
    chk({tag, "_busy_during_mm"}, busy, 1);
    @(negedge clk);
    chk({tag, "_busy_after_mm"}, busy, 0);
    chk({tag, "_ready_after_mm"}, s_ready, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_A"}, A_o, 0);
    chk({tag, "_B"}, B_o, 0);
  endtask

  // Behavioural core: latches A/B on start, answers LAT cycles later, abandoned by reset.
  initial begin
    core_state_t cs;
    int cnt;
    int ca[4];
    int cb[4];
    int cc[4];
    exp_t e;
    cs = CORE_IDLE;
    cnt = 0;
    mm_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        cs = CORE_IDLE;
        cnt = 0;
        mm_valid = 1'b0;
      end else if (cs == CORE_DONE) begin
        mm_valid = 1'b0;
        cs = CORE_IDLE;
      end else if (cs == CORE_STAGE1) begin
        chk("start_while_busy", start, 0);
        cnt--;
        if (cnt == 0) begin
          mm_valid = 1'b1;
          cs = CORE_DONE;
          done_cnt++;
          matmul2(ca, cb, cc);
          if (sb.size() == 0) begin
            chk("sb_underflow", 0, 1);
          end else begin
            e = sb.pop_front();
            for (int i = 0; i < 4; i++) begin
              chk("core_C", cc[i], e.c[i]);
              chk("held_A", $signed(A_o[i/2][i%2]), e.a[i]);
              chk("held_B", $signed(B_o[i/2][i%2]), e.b[i]);
            end
          end
        end
      end else if (start === 1'b1) begin
        starts++;
        for (int i = 0; i < 4; i++) begin
          ca[i] = $signed(A_o[i/2][i%2]);
          cb[i] = $signed(B_o[i/2][i%2]);
        end
        cnt = LAT;
        cs = CORE_STAGE1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v[8];
    int v2[8];
    int c[4];
    int prev;

    rst = 1'b1;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk("por_ready_after_release", s_ready, 1);

    // Basic frame
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    c = '{19, 22, 43, 50};
    push_exp(v, c);
    send_frame(v, 8, 7, 1'b0);
    chk("basic_start", start, 1);
    chk("basic_busy", busy, 1);
    chk("basic_ready_fire", s_ready, 0);
    @(negedge clk);
    chk("basic_start_one_cycle", start, 0);
    wait_result("basic");

    // Signed extremes
    v = '{-128, -128, -128, -128, 127, 127, 127, 127};
    c = '{-32512, -32512, -32512, -32512};
    push_exp(v, c);
    send_frame(v, 8, 7, 1'b0);
    chk("ext_start", start, 1);
    chk("ext_A00", $signed(A_o[0][0]), -128);
    chk("ext_B11", $signed(B_o[1][1]), 127);
    wait_result("ext");

    // Back-pressure: s_valid held across two frames
    v  = '{3, -4, 5, -6, 7, -8, 9, -10};
    v2 = '{-11, 12, -13, 14, 15, -16, 17, 18};
    push_model(v);
    push_model(v2);
    prev = done_cnt;
    send_frame(v, 8, 7, 1'b1);
    chk("bp_start", start, 1);
    chk("bp_ready_fire", s_ready, 0);
    send_frame(v2, 8, 7, 1'b0);
    chk("bp_first_done_before_second", done_cnt, prev + 1);
    wait_result("bp2");

    // Early s_last on element 5
    prev = starts;
    v = '{9, 9, 9, 9, 9, 0, 0, 0};
    send_frame(v, 5, 4, 1'b0);
    chk("early_frame_err", frame_err, 1);
    chk("early_no_start", start, 0);
    @(negedge clk);
    chk("early_err_one_cycle", frame_err, 0);
    v = '{2, 0, 0, 2, -1, 3, 4, -5};
    push_model(v);
    send_frame(v, 8, 7, 1'b0);
    chk("early_recover_start", start, 1);
    wait_result("early_next");
    chk("early_start_count", starts, prev + 1);

    // Missing s_last on element 8
    prev = starts;
    v = '{1, 1, 1, 1, 1, 1, 1, 1};
    send_frame(v, 8, -1, 1'b0);
    chk("miss_frame_err", frame_err, 1);
    chk("miss_no_start", start, 0);
    repeat (3) @(negedge clk);
    chk("miss_start_count", starts, prev);
    v = '{6, -7, 8, 1, 2, 3, -4, 5};
    push_model(v);
    send_frame(v, 8, 7, 1'b0);
    chk("miss_recover_start", start, 1);
    wait_result("miss_next");

    // Reset during WAIT
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    push_model(v);
    send_frame(v, 8, 7, 1'b0);
    @(negedge clk);
    chk("rw_in_wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    sb.delete();
    check_reset_vals("rst_wait");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wait_ready_after_release", s_ready, 1);
    v = '{-2, 4, -6, 8, 10, -12, 14, -16};
    push_model(v);
    send_frame(v, 8, 7, 1'b0);
    wait_result("rst_wait_next");

    // Reset mid-LOAD after element 3
    v = '{50, 60, 70, 0, 0, 0, 0, 0};
    send_frame(v, 3, -1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_vals("rst_load");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_load_ready_after_release", s_ready, 1);
    v = '{100, -100, 1, 2, -3, 4, 5, 127};
    push_model(v);
    send_frame(v, 8, 7, 1'b0);
    wait_result("rst_load_next");

    repeat (4) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    chk("total_starts", starts, 9);
    chk("total_results", done_cnt, 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matmul_operand_loader.md
Name: matmul_operand_loader

Overview:
- Upstream feeder for the 2x2 Strassen matrix-multiply core.
- Accepts a serial valid/ready stream of signed operands and assembles the A and B matrices in row-major order.
- Issues a one-cycle start to the core, then holds A/B stable and back-pressures the stream until the core reports valid.
- Frame errors (s_last misplaced) are detected, the frame is discarded, and no start is issued.

Parameters:
- BIT_PREC, 8, operand width in bits (signed two's complement).
- N, 2, matrix dimension; frame length is FRAME = 2*N*N elements (8 at default).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  upstream element valid.
- s_ready  output  1  loader can accept an element.
- s_data  input  BIT_PREC signed  element value.
- s_last  input  1  marks the final element of a frame.
- A  output  [N][N] x BIT_PREC signed  A operand to the core.
- B  output  [N][N] x BIT_PREC signed  B operand to the core.
- start  output  1  one-cycle pulse to the core.
- mm_valid  input  1  core result-valid pulse.
- busy  output  1  high from start until mm_valid is observed.
- frame_err  output  1  one-cycle pulse on a malformed frame.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high, port rst.
- Reset values: state=IDLE, count=0, A/B all zero, start=0, busy=0, frame_err=0. s_ready=0 while in IDLE.
- Transfer rule: an element transfers on a rising edge where s_valid && s_ready.
- s_ready is decoded from state only, (state==LOAD). It never depends on s_valid.
- State IDLE: moves to LOAD unconditionally on the first edge after rst deasserts.
- State LOAD (s_ready=1): on each transfer the element is written at index count.
  - count 0..N*N-1 go to A[count/N][count%N].
  - count N*N..2N*N-1 go to B, with the same row-major mapping.
  - count increments; its width is clog2(FRAME).
- Normal frame end: transfer with count==FRAME-1 and s_last=1 -> count=0, go to FIRE.
- Early s_last: transfer with s_last=1 and count<FRAME-1 -> frame_err=1 for one cycle, count=0, stay in LOAD.
  - Partially written A/B contents are don't-care.
  - No start is issued.
- Missing s_last: transfer with count==FRAME-1 and s_last=0 -> same handling as early s_last; the frame is discarded.
- State FIRE (s_ready=0): start=1 for exactly this one cycle, busy=1, then go to WAIT.
- State WAIT (s_ready=0, busy=1): A and B are held constant, because the core reads them in its first two cycles.
  - On mm_valid=1 -> busy=0, go to LOAD; a new frame is accepted from the next edge.
- Latency: start is asserted the cycle after the last element transfers. Minimum frame-to-frame period is FRAME + 2 + core latency.
- mm_valid outside WAIT is ignored, with no error.
- start is never asserted twice without an intervening mm_valid.
- Reset mid-operation (any state): immediate return to reset values. A partial frame is lost. Any in-flight core result is not tracked.
- Arithmetic: none; data is stored verbatim with sign preserved.

Decomposition:
- Shared package matmul_pkg holds:
  - BIT_PREC and N defaults;
  - localparam FRAME;
  - loader state enum {IDLE, LOAD, FIRE, WAIT}.
- Type the core's state enum there too, so the core and loader share it.
- Single module; no sub-module. The element counter and address decode are too small to split.

Test Plan:
- Basic frame, loader driving the core: stream 1,2,3,4,5,6,7,8 with s_last on the 8th.
  - Expect start exactly one cycle after the 8th transfer.
  - Expect core C=[[19,22],[43,50]] with valid.
  - Expect busy to fall and s_ready to rise the cycle after mm_valid.
- Signed extremes: A all -128, B all 127 -> A/B outputs hold -128/127 bit-exact; core C all -32512.
- Back-pressure: hold s_valid=1 continuously across two frames.
  - Expect s_ready=0 from FIRE through mm_valid.
  - Expect no element dropped or duplicated; the second frame's values appear in A/B only after the first mm_valid.
- Early s_last on element 5 -> frame_err one-cycle pulse, no start; the next correct 8-element frame computes normally.
- Missing s_last on element 8 -> frame_err, no start, count restarts at 0.
- Reset during WAIT and during mid-LOAD (element 3) -> all outputs at reset values while rst=1.
  - Expect s_ready high one cycle after release.
  - Expect the next full frame to produce a correct result.
